// File: rtl/vcpu_it_issue_if.sv
// Handshake and status bundle between the Thumb command source, the IT issue
// stage and vcpu. The slave side is the issue stage.
interface vcpu_it_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_cmd;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_cmd;
  logic        out_exec;
  logic        in_it_block;
  logic        it_error;
  logic [7:0]  it_state;
  logic        nf;
  logic        zf;
  logic        cf;
  logic        vf;

  modport slave (
    input  in_valid, in_cmd, flush, out_ready, nf, zf, cf, vf,
    output in_ready, out_valid, out_cmd, out_exec, in_it_block, it_error, it_state
  );

  modport master (
    output in_valid, in_cmd, flush, out_ready, nf, zf, cf, vf,
    input  in_ready, out_valid, out_cmd, out_exec, in_it_block, it_error, it_state
  );
endinterface

// File: rtl/vcpu_it_issue.sv
// Single-entry Thumb issue stage: consumes IT instructions, tracks ITSTATE and
// tags each issued command with its condition and in-IT-block flag.
module vcpu_it_issue (
  input logic            sck,
  input logic            rst_n,
  vcpu_it_issue_if.slave bus
);
  logic        r_out_valid;
  logic [15:0] r_out_cmd;
  logic [3:0]  r_cond;
  logic        r_in_it_block;
  logic        r_it_error;
  logic [7:0]  r_it_state;

  logic        w_in_ready;
  logic        w_accept;
  logic        w_is_it;
  logic        w_it_legal;
  logic        w_in_blk_next;
  logic        w_pass;
  logic [3:0]  w_fc;
  logic [3:0]  w_mask;
  logic [7:0]  w_it_adv;

  assign w_fc          = bus.in_cmd[7:4];
  assign w_mask        = bus.in_cmd[3:0];
  assign w_in_blk_next = (r_it_state[3:0] != 4'h0);
  assign w_is_it       = (bus.in_cmd[15:8] == 8'hBF) && (w_mask != 4'h0);
  assign w_it_legal    = w_is_it && !w_in_blk_next && (w_fc != 4'hF) &&
                         ((w_fc != 4'hE) || (w_mask == 4'b1000));

  // Last slot of a block (low three bits empty) retires ITSTATE entirely.
  assign w_it_adv = (r_it_state[2:0] == 3'b000) ? 8'h00
                  : {r_it_state[7:5], r_it_state[3:0], 1'b0};

  // No path from in_valid: ready depends only on the entry and vcpu/flush.
  assign w_in_ready = !bus.flush && (!r_out_valid || bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;

  always_comb begin
    w_pass = 1'b1;
    case (r_cond)
      4'h0: w_pass = bus.zf;
      4'h1: w_pass = !bus.zf;
      4'h2: w_pass = bus.cf;
      4'h3: w_pass = !bus.cf;
      4'h4: w_pass = bus.nf;
      4'h5: w_pass = !bus.nf;
      4'h6: w_pass = bus.vf;
      4'h7: w_pass = !bus.vf;
      4'h8: w_pass = bus.cf && !bus.zf;
      4'h9: w_pass = !bus.cf || bus.zf;
      4'hA: w_pass = (bus.nf == bus.vf);
      4'hB: w_pass = (bus.nf != bus.vf);
      4'hC: w_pass = !bus.zf && (bus.nf == bus.vf);
      4'hD: w_pass = bus.zf || (bus.nf != bus.vf);
      default: w_pass = 1'b1;
    endcase
  end

  always_ff @(posedge sck or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid   <= 1'b0;
      r_out_cmd     <= 16'h0000;
      r_cond        <= 4'hE;
      r_in_it_block <= 1'b0;
      r_it_error    <= 1'b0;
      r_it_state    <= 8'h00;
    end else if (bus.flush) begin
      r_out_valid   <= 1'b0;
      r_cond        <= 4'hE;
      r_in_it_block <= 1'b0;
      r_it_error    <= 1'b0;
      r_it_state    <= 8'h00;
    end else if (w_accept) begin
      r_it_error <= w_is_it && !w_it_legal;
      if (w_is_it) begin
        // IT is swallowed; any held command was drained by this same handshake.
        r_out_valid <= 1'b0;
        r_it_state  <= w_it_legal ? bus.in_cmd[7:0] : w_it_adv;
      end else begin
        r_out_valid   <= 1'b1;
        r_out_cmd     <= bus.in_cmd;
        r_cond        <= w_in_blk_next ? r_it_state[7:4] : 4'hE;
        r_in_it_block <= w_in_blk_next;
        r_it_state    <= w_it_adv;
      end
    end else begin
      r_it_error <= 1'b0;
      if (bus.out_ready) r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_cmd     = r_out_cmd;
  assign bus.out_exec    = r_out_valid && w_pass;
  assign bus.in_it_block = r_in_it_block;
  assign bus.it_error    = r_it_error;
  assign bus.it_state    = r_it_state;
endmodule

// File: tb/tb_vcpu_it_issue.sv
// Bench for vcpu_it_issue: directed vector table, hand-written stall/reset
// sequences, then random traffic against a queue-of-conditions model.
module tb_vcpu_it_issue;
  logic sck;
  logic rst_n;
  int   checks;
  int   failures;

  vcpu_it_issue_if bus ();

  vcpu_it_issue dut (
    .sck  (sck),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial sck = 1'b0;
  always #5 sck = ~sck;

  typedef struct {
    logic        vld;
    logic [15:0] cmd;
    logic        rdy;
    logic        fl;
    logic        z;
    logic        e_ov;
    logic [15:0] e_cmd;
    logic        e_exec;
    logic        e_blk;
    logic        e_err;
    logic [7:0]  e_state;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(logic vld, logic [15:0] cmd, logic fl, logic z,
                              logic e_ov, logic [15:0] e_cmd, logic e_exec,
                              logic e_blk, logic e_err, logic [7:0] e_state);
    vec_t v;
    v.vld = vld; v.cmd = cmd; v.rdy = 1'b1; v.fl = fl; v.z = z;
    v.e_ov = e_ov; v.e_cmd = e_cmd; v.e_exec = e_exec;
    v.e_blk = e_blk; v.e_err = e_err; v.e_state = e_state;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural condition check: base test chosen by cond[3:1], inverted by cond[0].
  function automatic logic ref_pass(logic [3:0] c, logic n, logic z, logic cy, logic v);
    logic b;
    case (c[3:1])
      3'd0: b = z;
      3'd1: b = cy;
      3'd2: b = n;
      3'd3: b = v;
      3'd4: b = cy & ~z;
      3'd5: b = (n == v);
      3'd6: b = ~z & (n == v);
      default: b = 1'b1;
    endcase
    return (c[3:1] != 3'd7 && c[0]) ? ~b : b;
  endfunction

  task automatic drive(input logic v, input logic [15:0] c, input logic r, input logic f);
    bus.in_valid  = v;
    bus.in_cmd    = c;
    bus.out_ready = r;
    bus.flush     = f;
  endtask

  task automatic cyc(input logic v, input logic [15:0] c, input logic r, input logic f);
    drive(v, c, r, f);
    @(posedge sck);
    @(negedge sck);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " out_valid"},   16'(bus.out_valid),   16'h0);
    chk({tag, " out_cmd"},     bus.out_cmd,          16'h0);
    chk({tag, " in_it_block"}, 16'(bus.in_it_block), 16'h0);
    chk({tag, " it_error"},    16'(bus.it_error),    16'h0);
    chk({tag, " it_state"},    16'(bus.it_state),    16'h0);
    chk({tag, " in_ready"},    16'(bus.in_ready),    16'h1);
    chk({tag, " out_exec"},    16'(bus.out_exec),    16'h0);
  endtask

  // Reference model state
  logic       m_ov, m_blk, m_err;
  logic [15:0] m_cmd;
  logic [3:0] m_cond;
  logic [3:0] q[$];

  task automatic model_step(input logic v, input logic [15:0] c, input logic r, input logic f);
    logic rdy, is_it, legal;
    logic [3:0] fc, mask;
    int size;
    rdy = !f && (!m_ov || r);
    fc = c[7:4];
    mask = c[3:0];
    if (f) begin
      m_ov = 0; m_blk = 0; m_cond = 4'hE; m_err = 0; q.delete();
    end else if (v && rdy) begin
      is_it = (c[15:8] == 8'hBF) && (mask != 0);
      if (is_it) begin
        legal = (q.size() == 0) && (fc != 4'hF) && (fc != 4'hE || mask == 4'b1000);
        m_err = !legal;
        m_ov = 0;
        if (legal) begin
          size = mask[0] ? 4 : mask[1] ? 3 : mask[2] ? 2 : 1;
          q.push_back(fc);
          for (int k = 1; k < size; k++) q.push_back({fc[3:1], mask[4-k]});
        end else if (q.size() != 0) begin
          void'(q.pop_front());
        end
      end else begin
        m_err = 0;
        m_ov = 1;
        m_cmd = c;
        if (q.size() != 0) begin
          m_cond = q.pop_front();
          m_blk = 1;
        end else begin
          m_cond = 4'hE;
          m_blk = 0;
        end
      end
    end else begin
      m_err = 0;
      if (r) m_ov = 0;
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    bus.nf = 0; bus.zf = 1; bus.cf = 0; bus.vf = 0;
    drive(0, 16'h0, 1, 0);
    rst_n = 0;
    #12;
    chk_reset_vals("reset");
    @(negedge sck);
    rst_n = 1;

    // ITTE EQ, hint, illegal ITs, ITTT NE with flush
    vecs[0]  = mk(1, 16'hBF06, 0, 1, 0, 16'h0000, 0, 0, 0, 8'h06);
    vecs[1]  = mk(1, 16'h1C40, 0, 1, 1, 16'h1C40, 1, 1, 0, 8'h0C);
    vecs[2]  = mk(1, 16'h1C49, 0, 1, 1, 16'h1C49, 1, 1, 0, 8'h18);
    vecs[3]  = mk(1, 16'h1C52, 0, 1, 1, 16'h1C52, 0, 1, 0, 8'h00);
    vecs[4]  = mk(1, 16'h1C5B, 0, 1, 1, 16'h1C5B, 1, 0, 0, 8'h00);
    vecs[5]  = mk(0, 16'h0000, 0, 1, 0, 16'h1C5B, 0, 0, 0, 8'h00);
    vecs[6]  = mk(1, 16'hBF00, 0, 1, 1, 16'hBF00, 1, 0, 0, 8'h00);
    vecs[7]  = mk(1, 16'hBFF8, 0, 1, 0, 16'hBF00, 0, 0, 1, 8'h00);
    vecs[8]  = mk(0, 16'h0000, 0, 1, 0, 16'hBF00, 0, 0, 0, 8'h00);
    vecs[9]  = mk(1, 16'hBF08, 0, 1, 0, 16'hBF00, 0, 0, 0, 8'h08);
    vecs[10] = mk(1, 16'hBF18, 0, 1, 0, 16'hBF00, 0, 0, 1, 8'h00);
    vecs[11] = mk(1, 16'h1C40, 0, 1, 1, 16'h1C40, 1, 0, 0, 8'h00);
    vecs[12] = mk(1, 16'hBF1E, 0, 0, 0, 16'h1C40, 0, 0, 0, 8'h1E);
    vecs[13] = mk(1, 16'h1C40, 0, 0, 1, 16'h1C40, 1, 1, 0, 8'h1C);
    vecs[14] = mk(1, 16'h1C49, 1, 0, 0, 16'h1C40, 0, 0, 0, 8'h00);
    vecs[15] = mk(1, 16'h1C52, 0, 0, 1, 16'h1C52, 1, 0, 0, 8'h00);
    vecs[16] = mk(0, 16'h0000, 0, 0, 0, 16'h1C52, 0, 0, 0, 8'h00);

    for (int i = 0; i < 17; i++) begin
      bus.zf = vecs[i].z;
      cyc(vecs[i].vld, vecs[i].cmd, vecs[i].rdy, vecs[i].fl);
      chk($sformatf("vec%0d out_valid", i),   16'(bus.out_valid),   16'(vecs[i].e_ov));
      chk($sformatf("vec%0d out_cmd", i),     bus.out_cmd,          vecs[i].e_cmd);
      chk($sformatf("vec%0d out_exec", i),    16'(bus.out_exec),    16'(vecs[i].e_exec));
      chk($sformatf("vec%0d in_it_block", i), 16'(bus.in_it_block), 16'(vecs[i].e_blk));
      chk($sformatf("vec%0d it_error", i),    16'(bus.it_error),    16'(vecs[i].e_err));
      chk($sformatf("vec%0d it_state", i),    16'(bus.it_state),    16'(vecs[i].e_state));
    end

    // Backpressure inside ITTTT EQ: slot 2 held for three cycles
    bus.zf = 1;
    cyc(1, 16'hBF01, 1, 0);
    chk("bp it load", 16'(bus.it_state), 16'h01);
    cyc(1, 16'hA001, 1, 0);
    chk("bp slot1 cmd", bus.out_cmd, 16'hA001);
    chk("bp slot1 state", 16'(bus.it_state), 16'h02);
    cyc(1, 16'hA002, 1, 0);
    chk("bp slot2 cmd", bus.out_cmd, 16'hA002);
    for (int s = 0; s < 3; s++) begin
      drive(1, 16'hA003, 0, 0);
      #1;
      chk("bp stall in_ready", 16'(bus.in_ready), 16'h0);
      @(posedge sck);
      @(negedge sck);
      chk("bp stall cmd", bus.out_cmd, 16'hA002);
      chk("bp stall state", 16'(bus.it_state), 16'h04);
      chk("bp stall valid", 16'(bus.out_valid), 16'h1);
    end
    cyc(1, 16'hA003, 1, 0);
    chk("bp slot3 cmd", bus.out_cmd, 16'hA003);
    chk("bp slot3 state", 16'(bus.it_state), 16'h08);
    chk("bp slot3 blk", 16'(bus.in_it_block), 16'h1);
    cyc(1, 16'hA004, 1, 0);
    chk("bp slot4 cmd", bus.out_cmd, 16'hA004);
    chk("bp slot4 state", 16'(bus.it_state), 16'h00);
    chk("bp slot4 blk", 16'(bus.in_it_block), 16'h1);
    cyc(0, 16'h0000, 1, 0);
    chk("bp drained", 16'(bus.out_valid), 16'h0);

    // Async reset while stalled inside a block
    cyc(1, 16'hBF01, 1, 0);
    cyc(1, 16'hA005, 1, 0);
    cyc(0, 16'h0000, 0, 0);
    chk("ar held", bus.out_cmd, 16'hA005);
    #2 rst_n = 0;
    #1 chk_reset_vals("async");
    #1 rst_n = 1;
    @(negedge sck);
    chk("ar post state", 16'(bus.it_state), 16'h00);

    // Random traffic against the model
    m_ov = 0; m_blk = 0; m_err = 0; m_cmd = 16'h0; m_cond = 4'hE; q.delete();
    for (int n = 0; n < 3000; n++) begin
      logic v, r, f;
      logic [15:0] c;
      logic [31:0] rnd;
      rnd = $urandom;
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 9) < 7);
      f = ($urandom_range(0, 15) == 0);
      c = rnd[0] ? {8'hBF, rnd[15:8]} : rnd[31:16];
      {bus.nf, bus.zf, bus.cf, bus.vf} = 4'($urandom);
      drive(v, c, r, f);
      #1;
      chk("rnd in_ready", 16'(bus.in_ready), 16'(!f && (!m_ov || r)));
      chk("rnd out_valid", 16'(bus.out_valid), 16'(m_ov));
      chk("rnd out_cmd", bus.out_cmd, m_cmd);
      chk("rnd out_exec", 16'(bus.out_exec),
          16'(m_ov && ref_pass(m_cond, bus.nf, bus.zf, bus.cf, bus.vf)));
      chk("rnd in_it_block", 16'(bus.in_it_block), 16'(m_blk));
      chk("rnd it_error", 16'(bus.it_error), 16'(m_err));
      chk("rnd block active", 16'(bus.it_state[3:0] != 0), 16'(q.size() != 0));
      if (q.size() == 0) chk("rnd it_state idle", 16'(bus.it_state), 16'h0);
      else chk("rnd it_state cond", 16'(bus.it_state[7:4]), 16'(q[0]));
      model_step(v, c, r, f);
      @(posedge sck);
      @(negedge sck);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end
endmodule

// File: doc/vcpu_it_issue.md
# vcpu_it_issue

Single-entry issue stage between the 16-bit Thumb command source and `vcpu`. It decodes and consumes IT instructions and tracks ITSTATE. Each following command leaves the stage tagged with its IT condition and the `in_it_block` flag. Conditional execution is resolved combinationally against the live `vcpu` flags when `vcpu` accepts the command.

## Interface
Parameters: none.

Ports:
- `sck` in 1: clock; all state updates on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: `in_cmd` is valid.
- `in_ready` out 1: the stage accepts `in_cmd` this cycle.
- `in_cmd` in 16: Thumb halfword.
- `flush` in 1: synchronous. Discards the stage entry and clears ITSTATE (branch taken / exception).
- `out_valid` out 1: `out_cmd` is held for `vcpu`.
- `out_ready` in 1: `vcpu` consumes `out_cmd` this cycle.
- `out_cmd` out 16: registered command.
- `out_exec` out 1: comb. Equals `out_valid` AND condpass(`cond_q`, live flags). When this is 0, `vcpu` treats the command as a NOP.
- `in_it_block` out 1: registered. `out_cmd` sits inside an IT block; drives `vcpu` flag-setting suppression.
- `it_error` out 1: registered, 1-cycle pulse for an illegal IT.
- `it_state` out 8: current ITSTATE, for debug and exception save.
- `nf`, `zf`, `cf`, `vf` in 1 each: live `vcpu` flags.

## Operation
- **Accept.** Transfer occurs when `in_valid && in_ready`. `in_ready = !out_valid || out_ready`, with no combinational path from `in_valid`.
- **IT decode.** An IT instruction matches `in_cmd[15:8] == 8'hBF` with `in_cmd[3:0] != 0`. Here firstcond = `[7:4]` and mask = `[3:0]`. A value of `8'hBF` with mask 0 is a hint and passes through as a normal command.
- **Legal IT.** An IT is legal when `!in_it_block_next` and firstcond != `4'hF`, and additionally when firstcond == `4'hE` the mask must be `4'b1000`.
  - A legal IT is consumed and never sent to `out_cmd`. It loads `it_state <= {firstcond, mask}`.
- **Illegal IT.** An illegal IT is also consumed and not issued. It pulses `it_error`, and ITSTATE advances as for a normal command.
- **Normal command.** On acceptance:
  - `out_cmd <= in_cmd`.
  - `cond_q <= (it_state[3:0] != 0) ? it_state[7:4] : 4'hE`.
  - `in_it_block <= (it_state[3:0] != 0)`.
  - `out_valid <= 1`.
  - ITSTATE then advances: if `it_state[2:0] == 0`, `it_state <= 0`; else `it_state[4:0] <= it_state[4:0] << 1` with `[7:5]` held.
- **Output register drain.** When `out_ready` is high and nothing is accepted, `out_valid <= 0`.
- **condpass(c, flags).**
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V.
  - 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V).
  - E and F are always 1.
- **Priority.** Reset > flush > accept/drain.
  - `flush` clears `out_valid`, `it_state`, `in_it_block` and `cond_q` (to E). It forces `in_ready = 0` in the flush cycle.
- **Stall.** While the stage holds a command and `out_ready` = 0, all registers hold, including `it_state`. The `out_exec` value is re-evaluated every cycle from the live flags.

## Timing
- **Reset values.** `out_valid` = 0, `out_cmd` = 0, `cond_q` = E, `in_it_block` = 0, `it_error` = 0, `it_state` = 0. Derived outputs: `in_ready` = 1 and `out_exec` = 0.
- **Latency.** Accepted at edge N gives `out_valid` = 1 after edge N. Throughput is 1 per cycle when `out_ready` = 1. An IT costs one `in_cmd` slot and produces no output.
- **Flag timing.** The `vcpu` flags written at edge N by the previous command must be visible in cycle N+1, when the next `out_cmd` is evaluated. The stage does not sample flags.
- **Flush mid-block.** Any remaining IT slots are dropped. The next accepted command issues with `cond_q` = E and `in_it_block` = 0.
- **Async reset mid-block or mid-stall.** All state clears immediately, and the held `out_cmd` is lost.
- **Simultaneous `flush` and `in_valid`.** Nothing is accepted.

## Test plan
- ITTE EQ. Stimulus: `in_cmd` `16'hBF06`, then `1C40`, `1C49`, `1C52`, `1C5B`, with Z = 1 throughout.
  - `it_state` goes 06 → 0C → 18 → 00.
  - Issued conds are EQ, EQ, NE, AL, with `out_exec` 1, 1, 0, 1.
  - `in_it_block` is 1, 1, 1, 0.
- Backpressure. During a 4-instruction ITTTT, hold `out_ready` = 0 for 3 cycles on slot 2.
  - `in_ready` = 0 and `it_state` is frozen during the stall.
  - No slot is lost or duplicated.
- Illegal IT. Send `BF18` inside an active block and `BFF8` outside a block.
  - `it_error` pulses once for each.
  - Neither is issued.
  - The in-block case advances ITSTATE.
- Hint. `BF00` is issued as a normal command with `in_it_block` = 0 and `out_exec` = 1.
- Flush. Assert `flush` after the first slot of ITTT NE.
  - Next cycle: `it_state` = 0 and `out_valid` = 0.
  - The following command issues with cond AL.
- Async reset. Assert `rst_n` low mid-stall. All outputs go to their reset values without waiting for an `sck` edge.
